// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: arms on start, captures one frame into the pixel buffer,
// then replays the buffer byte by byte into the UART transmitter.
module frame_dump_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              pixel_valid,
    input  logic [7:0]        pixel_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [7:0]        buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [7:0]        buf_rdata,
    output logic              uart_we,
    output logic [7:0]        uart_data,
    input  logic              uart_busy,
    output logic              busy,
    output logic              done,
    output logic              short_frame
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [ADDR_W:0]   TOTAL     = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_FS = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_SEND    = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [ADDR_W-1:0] wcount;
    logic [ADDR_W-1:0] rcount;
    logic [ADDR_W:0]   len;
    logic [GAP_W-1:0]  gap;
    logic              last_byte;
    logic              cap_full;
    logic              wc_zero;

    assign cap_full = pixel_valid && (wcount == LAST_ADDR);
    assign wc_zero  = (wcount == '0);

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) state_n = S_WAIT_FS;
                end
                S_WAIT_FS: begin
                    if (frame_start) state_n = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (cap_full) begin
                        state_n = S_RD_ADDR;
                    end else if (frame_end) begin
                        state_n = (pixel_valid || !wc_zero) ? S_RD_ADDR : S_DONE;
                    end
                end
                S_RD_ADDR: state_n = S_RD_WAIT;
                S_RD_WAIT: state_n = S_SEND;
                S_SEND: begin
                    if (!uart_busy) state_n = S_GAP;
                end
                S_GAP: begin
                    if (gap == GAP_ONE) state_n = last_byte ? S_DONE : S_RD_ADDR;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            wcount      <= '0;
            rcount      <= '0;
            len         <= '0;
            gap         <= '0;
            last_byte   <= 1'b0;
            buf_we      <= 1'b0;
            buf_waddr   <= '0;
            buf_wdata   <= '0;
            buf_raddr   <= '0;
            uart_we     <= 1'b0;
            uart_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state   <= state_n;
            busy    <= (state_n != S_IDLE) && (state_n != S_DONE);
            done    <= (state_n == S_DONE);
            buf_we  <= 1'b0;
            uart_we <= 1'b0;
            if (!abort) begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            wcount      <= '0;
                            rcount      <= '0;
                            len         <= '0;
                            short_frame <= 1'b0;
                        end
                    end
                    S_CAPTURE: begin
                        if (pixel_valid) begin
                            buf_we    <= 1'b1;
                            buf_waddr <= wcount;
                            buf_wdata <= pixel_data;
                        end
                        // the final write never bumps wcount, so it cannot wrap
                        if (cap_full) begin
                            len <= TOTAL;
                        end else begin
                            if (pixel_valid) wcount <= wcount + ADDR_W'(1);
                            if (frame_end) begin
                                short_frame <= 1'b1;
                                len <= {1'b0, wcount} + {{ADDR_W{1'b0}}, pixel_valid};
                            end
                        end
                    end
                    S_RD_ADDR: begin
                        buf_raddr <= rcount;
                    end
                    S_SEND: begin
                        if (!uart_busy) begin
                            uart_we   <= 1'b1;
                            uart_data <= buf_rdata;
                            rcount    <= rcount + ADDR_W'(1);
                            gap       <= GAP_LOAD;
                            last_byte <= (({1'b0, rcount} + (ADDR_W+1)'(1)) == len);
                        end
                    end
                    S_GAP: begin
                        gap <= gap - GAP_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// tb_frame_dump_ctrl: scoreboard bench, expected buffer writes and UART bytes
// are queued by the stimulus and popped by an independent monitor.
module tb_frame_dump_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start, abort, frame_start, frame_end, pixel_valid;
    logic [7:0]    pixel_data;
    logic          buf_we;
    logic [AW-1:0] buf_waddr, buf_raddr;
    logic [7:0]    buf_wdata, buf_rdata;
    logic          uart_we, uart_busy;
    logic [7:0]    uart_data;
    logic          busy, done, short_frame;

    logic [7:0]    mem [16];
    int            ucnt;
    logic          force_busy;
    int            cyc;
    int            n_cmp;
    int            n_err;
    int            n_uart;
    int            last_u;
    logic [11:0]   wq [$];
    logic [7:0]    uq [$];

    frame_dump_ctrl #(
        .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(AW), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .frame_start(frame_start), .frame_end(frame_end),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .uart_we(uart_we), .uart_data(uart_data), .uart_busy(uart_busy),
        .busy(busy), .done(done), .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        buf_rdata <= mem[buf_raddr];
        if (uart_we) ucnt <= 5;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end

    assign uart_busy = force_busy || (ucnt != 0);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (buf_we) begin
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL buf_write unexpected: addr %0h data %0h", buf_waddr, buf_wdata);
                end else begin
                    check("buf_write", {20'd0, buf_waddr, buf_wdata}, {20'd0, wq.pop_front()});
                end
            end
            if (uart_we) begin
                if (uq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL uart_byte unexpected: got %0h", uart_data);
                end else begin
                    check("uart_byte", {24'd0, uart_data}, {24'd0, uq.pop_front()});
                end
                if (last_u >= 0) check("uart_spacing_ge5", 32'(cyc - last_u >= 5), 32'd1);
                last_u = cyc;
                n_uart++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] base, input int nw, input int nu);
        for (int i = 0; i < nw; i++) wq.push_back({4'(i), 8'(base + 8'(i))});
        for (int i = 0; i < nu; i++) uq.push_back(8'(base + 8'(i)));
    endtask

    task automatic pixels(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = base + 8'(i);
            tick();
        end
        pixel_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic queues_empty(input string name);
        check({name, "_wq_left"}, 32'(wq.size()), 32'd0);
        check({name, "_uq_left"}, 32'(uq.size()), 32'd0);
    endtask

    initial begin
        int base_u;
        int k;
        n_cmp = 0; n_err = 0; n_uart = 0; last_u = -1;
        cyc = 0; ucnt = 0; force_busy = 1'b0;
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        frame_start = 1'b0; frame_end = 1'b0;
        pixel_valid = 1'b0; pixel_data = 8'h00;
        #1;
        check("reset_outputs", {3'd0, buf_we, buf_waddr, buf_wdata, buf_raddr,
              uart_we, uart_data, busy, done, short_frame}, 32'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // full frame with pre-arm pixels, pixel on frame_start, stray start
        expect_frame(8'h10, 8, 8);
        do_start();
        pixels(8'h55, 2);
        pixel_valid = 1'b1; pixel_data = 8'h66;
        fs();
        for (int i = 0; i < 10; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 8'h10 + 8'(i);
            start = (i == 3);
            tick();
        end
        start = 1'b0; pixel_valid = 1'b0;
        wait_done("full_done", 300);
        check("full_short", {31'd0, short_frame}, 32'd0);
        check("full_busy_low", {31'd0, busy}, 32'd0);
        queues_empty("full");

        // short frame
        expect_frame(8'hA0, 3, 3);
        do_start();
        fs();
        pixels(8'hA0, 3);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        wait_done("short_done", 200);
        check("short_flag", {31'd0, short_frame}, 32'd1);
        queues_empty("short");

        // frame_end coinciding with the last pixel
        expect_frame(8'hB0, 3, 3);
        do_start();
        fs();
        pixels(8'hB0, 2);
        pixel_valid = 1'b1; pixel_data = 8'hB2; frame_end = 1'b1;
        tick();
        pixel_valid = 1'b0; frame_end = 1'b0;
        wait_done("end_pix_done", 200);
        check("end_pix_short", {31'd0, short_frame}, 32'd1);
        queues_empty("end_pix");

        // empty frame
        base_u = n_uart;
        do_start();
        check("empty_short_cleared", {31'd0, short_frame}, 32'd0);
        fs();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("empty_done_next", {31'd0, done}, 32'd1);
        check("empty_short", {31'd0, short_frame}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("empty_no_uart", 32'(n_uart - base_u), 32'd0);

        // handshake: busy held for 100 cycles while in SEND
        expect_frame(8'h30, 8, 8);
        force_busy = 1'b1;
        do_start();
        fs();
        pixels(8'h30, 8);
        base_u = n_uart;
        for (int i = 0; i < 100; i++) tick();
        check("hs_held_no_uart", 32'(n_uart - base_u), 32'd0);
        check("hs_still_busy", {31'd0, busy}, 32'd1);
        force_busy = 1'b0;
        tick();
        check("hs_first_free_cycle", {31'd0, uart_we}, 32'd1);
        wait_done("hs_done", 300);
        check("hs_short", {31'd0, short_frame}, 32'd0);
        queues_empty("hs");

        // abort mid-dump, then restart from address 0
        expect_frame(8'h40, 8, 2);
        do_start();
        fs();
        pixels(8'h40, 8);
        base_u = n_uart;
        k = 0;
        while (n_uart - base_u < 2 && k < 200) begin
            tick();
            k++;
        end
        check("abort_two_sent", 32'(n_uart - base_u), 32'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        check("abort_no_more_uart", 32'(n_uart - base_u), 32'd2);
        queues_empty("abort");
        expect_frame(8'h50, 3, 3);
        do_start();
        fs();
        pixels(8'h50, 3);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        wait_done("restart_done", 200);
        queues_empty("restart");

        // asynchronous reset mid-capture
        expect_frame(8'h60, 2, 0);
        do_start();
        fs();
        pixel_valid = 1'b1; pixel_data = 8'h60; tick();
        pixel_data = 8'h61; tick();
        pixel_data = 8'h62;
        resetn = 1'b0;
        #1;
        check("rst_mid_outputs", {3'd0, buf_we, buf_waddr, buf_wdata, buf_raddr,
              uart_we, uart_data, busy, done, short_frame}, 32'd0);
        pixel_valid = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        check("rst_idle_busy", {31'd0, busy}, 32'd0);
        queues_empty("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_dump_ctrl.md
# frame_dump_ctrl

Sequencer that sits between the CSI-2 pixel path and the capture buffer / UART transmitter. On a start request it arms, waits for the next frame start, and writes exactly one frame of 8-bit pixels into the buffer. It then reads the buffer back in order and paces the bytes into the UART transmitter under its busy handshake. It replaces the free-running capture and dump logic in the top level with a single restartable controller.

## Interface
- `H_ACTIVE`, default 640: pixels per line.
- `V_ACTIVE`, default 480: lines per frame. TOTAL = H_ACTIVE*V_ACTIVE.
- `ADDR_W`, default 19: buffer address width. TOTAL must be ≤ 2^ADDR_W.
- `GAP_CYCLES`, default 16: minimum idle cycles after each UART write before `uart_busy` is sampled again. Must be ≥ 1.

Ports:
- `clk`, in, 1: single clock for all logic.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle request to capture and dump one frame.
- `abort`, in, 1: synchronous cancel.
- `frame_start`, in, 1: one-cycle frame start pulse from the CSI-2 receiver.
- `frame_end`, in, 1: one-cycle frame end pulse from the CSI-2 receiver.
- `pixel_valid`, in, 1: one pixel is present on `pixel_data`.
- `pixel_data`, in, 8: pixel byte.
- `buf_we`, out, 1: buffer write strobe.
- `buf_waddr`, out, ADDR_W: buffer write address.
- `buf_wdata`, out, 8: buffer write data.
- `buf_raddr`, out, ADDR_W: buffer read address. The buffer has a 1-cycle read latency.
- `buf_rdata`, in, 8: buffer read data.
- `uart_we`, out, 1: one-cycle UART write strobe.
- `uart_data`, out, 8: UART write data.
- `uart_busy`, in, 1: UART transmitter busy.
- `busy`, out, 1: high in any state except IDLE and DONE.
- `done`, out, 1: high while in DONE.
- `short_frame`, out, 1: sticky; `frame_end` arrived before TOTAL pixels.

## Operation
States: IDLE, WAIT_FS, CAPTURE, RD_ADDR, RD_WAIT, SEND, GAP, DONE.

- **IDLE / DONE**
  - `start` → WAIT_FS.
  - Clears `wcount`, `rcount` and `short_frame`.
- **WAIT_FS**
  - `frame_start` → CAPTURE.
  - `pixel_valid` and `frame_end` are ignored, including a `pixel_valid` in the same cycle as `frame_start`.
- **CAPTURE**
  - Each `pixel_valid` with `wcount` < TOTAL: register `buf_we`=1, `buf_waddr`=`wcount`, `buf_wdata`=`pixel_data`; then `wcount`++.
  - When the write making `wcount`=TOTAL occurs: `len`=TOTAL, go to RD_ADDR. Later pixels of the frame are ignored.
  - `frame_end` with `wcount` < TOTAL: `short_frame`=1, `len`=`wcount` (a `pixel_valid` in the same cycle is counted first).
    - If `len`=0 → DONE.
    - Otherwise → RD_ADDR.
  - `frame_start` while in CAPTURE is ignored.
- **RD_ADDR**: drive `buf_raddr`=`rcount`, go to RD_WAIT.
- **RD_WAIT**: one cycle for read latency, go to SEND.
- **SEND**
  - When `uart_busy`=0: `uart_we`=1 for one cycle, `uart_data`=`buf_rdata`, `rcount`++, load the gap counter with GAP_CYCLES, go to GAP.
  - Wait indefinitely while `uart_busy`=1.
- **GAP**
  - Decrement the gap counter. At 0:
    - If `rcount`=`len` → DONE.
    - Otherwise → RD_ADDR.
- **abort**
  - In any state: next state IDLE.
  - `buf_we` and `uart_we` are 0 from the next cycle.
  - A write already issued in the abort cycle completes.
  - `short_frame` holds its value.
- **start**: ignored unless in IDLE or DONE.
- **Counters**: `wcount` and `rcount` are ADDR_W bits, `len` is ADDR_W+1 bits. Counters never wrap, because limits are enforced before each increment.

## Timing
- Reset (async, `resetn`=0): state IDLE; all outputs 0, including `buf_waddr`, `buf_raddr` and `uart_data`.
- `start` at cycle n → `busy`=1 at n+1.
- `pixel_valid` at cycle n in CAPTURE → `buf_we`=1 with address and data at n+1. Throughput is 1 pixel per clock.
- Last capture write at n → state RD_ADDR at n+1, `buf_raddr`=0 at n+2.
- Per byte, with `uart_busy` low: RD_ADDR, RD_WAIT, SEND, then GAP_CYCLES cycles. That is a minimum of 3+GAP_CYCLES clocks per byte.
- `uart_we` is never high on two consecutive cycles.
- `uart_busy` is sampled only in SEND.
- `done` rises 1 cycle after the final GAP cycle. It stays high until `start` or `abort`.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
Scenarios use H_ACTIVE=4, V_ACTIVE=2, GAP_CYCLES=2; a UART model holds busy for 5 cycles starting 1 cycle after `uart_we`.

- **Full frame.** Stimulus: reset, then `start`, then `frame_start`, then 10 consecutive `pixel_valid` with data 0x10..0x19.
  - Writes go to addresses 0..7 with data 0x10..0x17; no write for 0x18 or 0x19.
  - UART receives 0x10..0x17 in order; `done`=1; `short_frame`=0.
- **Short frame.** Stimulus: 3 pixels 0xA0..0xA2, then `frame_end`.
  - `short_frame`=1; exactly 3 UART bytes, 0xA0..0xA2; then `done`.
- **Empty frame.** Stimulus: `frame_end` immediately after `frame_start`.
  - Goes to DONE with no `uart_we`; `short_frame`=1.
- **Pre-arm pixels and stray pulses.**
  - `pixel_valid` in WAIT_FS or in the same cycle as `frame_start` → no `buf_we`.
  - `start` during CAPTURE → no effect.
- **Handshake.** Stimulus: hold `uart_busy`=1 for 100 cycles while in SEND.
  - `uart_we` stays 0; it fires on the first cycle busy is low.
  - Gap between consecutive `uart_we` ≥ 3+GAP_CYCLES.
- **Abort and reset.**
  - `abort` mid-dump → `busy`=0 the next cycle, no further `uart_we`; a new `start` re-captures from address 0.
  - `resetn` low mid-capture → all outputs 0 immediately.
